// File: rtl/lib_allocator_pkg.sv
// lib_allocator_pkg
// Shared types and helpers for the iSLIP allocator slice.
//   alloc_state_t : allocator FSM states (idle, iterating, result pulse)
//   idxWidth()    : bit width of a binary index into a vector of n entries
package lib_allocator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } alloc_state_t;

   // A one-entry vector still gets a one-bit index so no zero-width signals appear.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lib_rr_arbiter_idx.sv
// lib_rr_arbiter_idx
// Combinational programmable-priority arbiter: grants the first requester at
// an index >= start_i, wrapping from W-1 back to 0.
//   req_i   : request vector, W bits
//   start_i : index of the highest-priority position
//   grant_o : one-hot grant, all zero when nothing requests
//   valid_o : high when grant_o has a bit set
module lib_rr_arbiter_idx
   import lib_allocator_pkg::*;
#(
   parameter int W = 4,
   localparam int IW = idxWidth(W)
) (
   input  logic [W-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic [W-1:0]  grant_o,
   output logic          valid_o
);

   // Two passes: first the upper segment [start..W-1], then the wrapped
   // segment [0..start-1]; the first hit in scan order wins.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      for (int b = 0; b < W; b++) begin
         if (!valid_o && req_i[b] && (b >= int'(start_i))) begin
            grant_o[b] = 1'b1;
            valid_o    = 1'b1;
         end
      end
      for (int b = 0; b < W; b++) begin
         if (!valid_o && req_i[b]) begin
            grant_o[b] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lib_allocator_islip_iter.sv
// lib_allocator_islip_iter
// Multi-iteration iSLIP allocator matching N inputs to M outputs, one
// request/grant/accept iteration per clock, behind a valid/ready handshake.
//   clk, reset_n : clock, synchronous active-low reset
//   i_valid      : request matrix valid
//   i_request    : i_request[i][j] = input i requests output j
//   o_ready      : allocator idle and able to take a new matrix
//   o_valid      : one-cycle pulse, o_grant holds a fresh match
//   o_grant      : o_grant[j][i] = output j granted to input i
module lib_allocator_islip_iter
   import lib_allocator_pkg::*;
#(
   parameter int N    = 4,
   parameter int M    = 4,
   parameter int ITER = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_valid,
   input  logic [0:N-1][0:M-1]  i_request,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [0:M-1][0:N-1]  o_grant
);

   localparam int NW = idxWidth(N);
   localparam int MW = idxWidth(M);
   localparam int KW = idxWidth(ITER + 1);

   alloc_state_t               state_q;
   logic [KW-1:0]              iter_q;
   logic [0:N-1][0:M-1]        req_q;
   logic [0:M-1][0:N-1]        match_q, match_d;
   logic [0:M-1][0:N-1]        grant_q;
   logic                       valid_q;
   logic [NW-1:0]              gPtr_q [M];
   logic [MW-1:0]              aPtr_q [N];
   logic [NW-1:0]              gStage_q [M], gStage_d [M];
   logic [MW-1:0]              aStage_q [N], aStage_d [N];

   logic [N-1:0]               inMatched, inNext;
   logic [M-1:0]               outMatched, outNext;
   logic [N-1:0]               grantReq [M];
   logic [N-1:0]               grantOh [M];
   logic [M-1:0]               grantVld;
   logic [M-1:0]               acceptReq [N];
   logic [M-1:0]               acceptOh [N];
   logic [N-1:0]               acceptVld;
   logic                       moreWork;

   // Request phase: only unmatched inputs ask unmatched outputs.
   always_comb begin
      inMatched  = '0;
      outMatched = '0;
      for (int j = 0; j < M; j++) begin
         for (int i = 0; i < N; i++) begin
            if (match_q[j][i]) begin
               inMatched[i]  = 1'b1;
               outMatched[j] = 1'b1;
            end
         end
      end
      for (int j = 0; j < M; j++) begin
         grantReq[j] = '0;
         for (int i = 0; i < N; i++) begin
            grantReq[j][i] = req_q[i][j] & ~inMatched[i] & ~outMatched[j];
         end
      end
   end

   for (genvar j = 0; j < M; j++) begin : g_grantArb
      lib_rr_arbiter_idx #(.W(N)) u_grantArb (
         .req_i   (grantReq[j]),
         .start_i (gPtr_q[j]),
         .grant_o (grantOh[j]),
         .valid_o (grantVld[j])
      );
   end

   // Accept phase: each input sees the set of outputs that granted it.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         acceptReq[i] = '0;
         for (int j = 0; j < M; j++) begin
            acceptReq[i][j] = grantOh[j][i] & grantVld[j];
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_acceptArb
      lib_rr_arbiter_idx #(.W(M)) u_acceptArb (
         .req_i   (acceptReq[i]),
         .start_i (aPtr_q[i]),
         .grant_o (acceptOh[i]),
         .valid_o (acceptVld[i])
      );
   end

   // Fold accepted pairs into the match, stage first-iteration pointer moves,
   // and decide whether another iteration could still add a pair.
   always_comb begin
      match_d  = match_q;
      gStage_d = gStage_q;
      aStage_d = aStage_q;
      inNext   = inMatched | acceptVld;
      outNext  = outMatched;
      moreWork = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < M; j++) begin
            if (acceptOh[i][j]) begin
               match_d[j][i] = 1'b1;
               outNext[j]    = 1'b1;
               if (iter_q == KW'(1)) begin
                  gStage_d[j] = (i == N - 1) ? '0 : NW'(i + 1);
                  aStage_d[i] = (j == M - 1) ? '0 : MW'(j + 1);
               end
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < M; j++) begin
            if (req_q[i][j] && !inNext[i] && !outNext[j]) begin
               moreWork = 1'b1;
            end
         end
      end
   end

   // Allocator FSM. Staged pointers start as copies of the live ones so
   // unmatched ports keep their position when the staged set commits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         iter_q   <= '0;
         req_q    <= '0;
         match_q  <= '0;
         grant_q  <= '0;
         valid_q  <= 1'b0;
         gPtr_q   <= '{default: '0};
         aPtr_q   <= '{default: '0};
         gStage_q <= '{default: '0};
         aStage_q <= '{default: '0};
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  req_q    <= i_request;
                  match_q  <= '0;
                  iter_q   <= KW'(1);
                  gStage_q <= gPtr_q;
                  aStage_q <= aPtr_q;
                  state_q  <= ST_ITER;
               end
            end
            ST_ITER: begin
               match_q  <= match_d;
               gStage_q <= gStage_d;
               aStage_q <= aStage_d;
               if ((iter_q == KW'(ITER)) || !moreWork) begin
                  state_q <= ST_DONE;
                  valid_q <= 1'b1;
                  grant_q <= match_d;
               end else begin
                  iter_q <= iter_q + 1'b1;
               end
            end
            ST_DONE: begin
               gPtr_q  <= gStage_q;
               aPtr_q  <= aStage_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_ready = (state_q == ST_IDLE);
   assign o_valid = valid_q;
   assign o_grant = grant_q;

endmodule

// File: tb/tb_lib_allocator_islip_iter.sv
// tb_lib_allocator_islip_iter
// Self-checking bench: directed scenarios plus random request matrices,
// compared against an iteration-level iSLIP model with its own pointers.
module tb_lib_allocator_islip_iter;

   localparam int N    = 4;
   localparam int M    = 4;
   localparam int ITER = 3;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                i_valid = 1'b0;
   logic [0:N-1][0:M-1] i_request = '0;
   logic                o_ready;
   logic                o_valid;
   logic [0:M-1][0:N-1] o_grant;

   int testCount = 0;
   int failCount = 0;
   int gRef [M];
   int aRef [N];

   always #5 clk = ~clk;

   lib_allocator_islip_iter #(.N(N), .M(M), .ITER(ITER)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_valid   (i_valid),
      .i_request (i_request),
      .o_ready   (o_ready),
      .o_valid   (o_valid),
      .o_grant   (o_grant)
   );

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      for (int j = 0; j < M; j++) gRef[j] = 0;
      for (int i = 0; i < N; i++) aRef[i] = 0;
   endtask

   // Reference iSLIP: round-robin by modular distance from each pointer.
   task automatic modelAlloc(input logic [0:N-1][0:M-1] req,
                             output logic [0:M-1][0:N-1] match, output int kLast);
      bit inM [N];
      bit outM [M];
      int grantTo [M];
      int newG [M];
      int newA [N];
      bit stop;
      match = '0;
      kLast = 0;
      stop  = 1'b0;
      for (int i = 0; i < N; i++) begin inM[i] = 1'b0; newA[i] = aRef[i]; end
      for (int j = 0; j < M; j++) begin outM[j] = 1'b0; newG[j] = gRef[j]; end
      for (int k = 1; k <= ITER && !stop; k++) begin
         for (int j = 0; j < M; j++) begin
            grantTo[j] = -1;
            if (!outM[j]) begin
               for (int d = 0; d < N; d++) begin
                  int cand;
                  cand = (gRef[j] + d) % N;
                  if (grantTo[j] < 0 && !inM[cand] && req[cand][j]) grantTo[j] = cand;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            int pick;
            pick = -1;
            if (!inM[i]) begin
               for (int d = 0; d < M; d++) begin
                  int cand;
                  cand = (aRef[i] + d) % M;
                  if (pick < 0 && grantTo[cand] == i) pick = cand;
               end
            end
            if (pick >= 0) begin
               match[pick][i] = 1'b1;
               inM[i]    = 1'b1;
               outM[pick] = 1'b1;
               if (k == 1) begin
                  newG[pick] = (i + 1) % N;
                  newA[i]    = (pick + 1) % M;
               end
            end
         end
         kLast = k;
         stop  = 1'b1;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++)
               if (req[i][j] && !inM[i] && !outM[j]) stop = 1'b0;
      end
      for (int j = 0; j < M; j++) gRef[j] = newG[j];
      for (int i = 0; i < N; i++) aRef[i] = newA[i];
   endtask

   // Waits for o_ready, performs one handshake and checks every following
   // cycle until the allocator is idle again. Optionally keeps i_valid high
   // with junk matrices while busy; those must be ignored.
   task automatic applyStimulus(input logic [0:N-1][0:M-1] req, input bit holdValid,
                                input string tag, output logic [0:M-1][0:N-1] seenGrant);
      logic [0:M-1][0:N-1] expGrant;
      int kl;
      int waited;
      seenGrant = '0;
      waited = 0;
      @(negedge clk);
      while (!o_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!o_ready) begin
         checkOutput({tag, "/readyTimeout"}, 64'(o_ready), 64'(1));
         return;
      end
      i_valid   = 1'b1;
      i_request = req;
      modelAlloc(req, expGrant, kl);
      @(posedge clk);
      for (int c = 1; c <= kl + 2; c++) begin
         @(negedge clk);
         if (c <= kl + 1) checkOutput($sformatf("%s/busyReady c%0d", tag, c), 64'(o_ready), 64'(0));
         else             checkOutput($sformatf("%s/idleReady", tag), 64'(o_ready), 64'(1));
         if (c == kl + 1) begin
            checkOutput($sformatf("%s/validPulse", tag), 64'(o_valid), 64'(1));
            checkOutput($sformatf("%s/grant", tag), 64'(o_grant), 64'(expGrant));
            seenGrant = o_grant;
         end else begin
            checkOutput($sformatf("%s/validLow c%0d", tag, c), 64'(o_valid), 64'(0));
         end
         if (holdValid && c <= kl) begin
            i_valid   = 1'b1;
            i_request = (N*M)'($urandom);
         end else begin
            i_valid = 1'b0;
         end
      end
      // Result must persist past the pulse.
      checkOutput({tag, "/grantHold"}, 64'(o_grant), 64'(expGrant));
   endtask

   initial begin
      logic [0:N-1][0:M-1] req;
      logic [0:M-1][0:N-1] seen;
      int waited;

      resetModel();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("reset/ready", 64'(o_ready), 64'(1));
      checkOutput("reset/valid", 64'(o_valid), 64'(0));
      checkOutput("reset/grant", 64'(o_grant), 64'(0));

      // Scenario 1: all-ones from reset pointers.
      applyStimulus('1, 1'b0, "s1", seen);
      checkOutput("s1/const", 64'(seen), 64'h8420);
      // Scenario 2: all-ones again with moved pointers gives a full match.
      applyStimulus('1, 1'b0, "s2", seen);
      checkOutput("s2/const", 64'(seen), 64'h4821);
      // Scenario 3: single request in2->out3, early termination.
      req = '0;
      req[2][3] = 1'b1;
      applyStimulus(req, 1'b0, "s3", seen);
      checkOutput("s3/const", 64'(seen), 64'h0002);
      // All-zero request still costs one iteration.
      applyStimulus('0, 1'b0, "zero", seen);
      applyStimulus('1, 1'b0, "s4ones", seen);
      // Junk matrices while busy must be ignored.
      applyStimulus('1, 1'b1, "hold", seen);

      // Reset mid-allocation: rerun s1 from reset, start s2, abort in cycle 2.
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      resetModel();
      applyStimulus('1, 1'b0, "r1", seen);
      waited = 0;
      while (!o_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("rst/preReady", 64'(o_ready), 64'(1));
      i_valid   = 1'b1;
      i_request = '1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      checkOutput("rst/c1valid", 64'(o_valid), 64'(0));
      @(negedge clk);
      checkOutput("rst/c2valid", 64'(o_valid), 64'(0));
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("rst/inValid", 64'(o_valid), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rst/postValid", 64'(o_valid), 64'(0));
      checkOutput("rst/postGrant", 64'(o_grant), 64'(0));
      checkOutput("rst/postReady", 64'(o_ready), 64'(1));
      resetModel();
      applyStimulus('1, 1'b0, "r2", seen);
      checkOutput("r2/const", 64'(seen), 64'h8420);

      // Random matrices of varying density.
      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 2))
            0:       req = (N*M)'($urandom & $urandom);
            1:       req = (N*M)'($urandom);
            default: req = (N*M)'($urandom | $urandom);
         endcase
         applyStimulus(req, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t), seen);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/lib_allocator_islip_iter.md
# lib_allocator_islip_iter

Parametrised multi-iteration iSLIP allocator: matches N requesters (inputs) to M resources (outputs) over up to ITER request/grant/accept iterations, one iteration per clock. It adds proper per-output grant pointers, per-input accept pointers and early termination. A valid/ready request handshake sits in front of it. It sits between VOQ request generation and the switch-fabric crossbar configuration register.

## Interface
- N, 4: number of inputs, ≥2, any integer (non power-of-two allowed)
- M, 4: number of outputs, ≥2, any integer
- ITER, 3: maximum iterations per allocation, ≥1
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_valid  in  1  request matrix valid
- i_request  in  [0:N-1][0:M-1]  i_request[i][j]=1: input i requests output j
- o_ready  out  1  allocator idle, accepts i_request
- o_valid  out  1  one-cycle pulse, o_grant holds new match
- o_grant  out  [0:M-1][0:N-1]  o_grant[j][i]=1: output j granted to input i; ≤1 bit set per row and per column

## Operation
- States: IDLE, ITER, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, latch i_request, clear the match matrix, set iteration counter k=1, and go to ITER. i_valid is ignored in any other state.
- ITER: each cycle performs one iteration on the latched matrix.
  - Request: an unmatched input requests every unmatched output it has a bit for.
  - Grant: each unmatched output picks one requesting input, round-robin starting at index g[j] (first requester at index ≥g[j], wrapping N-1→0).
  - Accept: each input receiving grants picks one output, round-robin starting at a[i] (wrap M-1→0). Accepted pairs are added to the match matrix.
- Pointer rule: only in iteration 1, for each accepted pair (i,j), stage g[j]←(i+1) mod N and a[i]←(j+1) mod M. Staged values commit on the DONE cycle. Iterations 2..ITER use the uncommitted (old) pointers. Pointers of unmatched ports never move.
- Termination after iteration k: go to DONE if k==ITER, or if no unmatched input has a request to an unmatched output. Otherwise k←k+1.
- DONE: o_valid=1 and o_grant=match matrix, then go to IDLE. o_grant holds its value until the next DONE.
- Reset (any state, including mid-allocation):
  - state=IDLE; o_valid=0, o_grant='0, o_ready=1 from the first cycle after reset is released.
  - All g and a pointers reset to 0; staged pointers and the latched request are discarded.
- Pointer width $clog2(N) / $clog2(M), binary index. Wrap is by explicit compare-to-max, not by natural overflow.

## Timing
- Cycle 0: handshake cycle. Iteration k is registered at the end of cycle k. DONE (o_valid) occurs in cycle k_last+1. IDLE (o_ready=1) occurs in cycle k_last+2.
- Latency 2 cycles (best case) to ITER+1 cycles (worst case). Minimum handshake spacing is k_last+2 cycles.
- o_ready is 0 during cycles 1..k_last+1.
- The all-zero request still costs one iteration: o_valid in cycle 2 with o_grant='0 and pointers unchanged.

## Structure
- Package lib_allocator_pkg: state enum (IDLE, ITER, DONE) and an index-width helper function. No parameters live in the package.
- Sub-module lib_rr_arbiter_idx: combinational programmable-priority arbiter. Inputs are a request vector of width W and a start index; outputs are a one-hot grant and a grant-valid flag. It is instantiated M times (grant stage, W=N) and N times (accept stage, W=M).
- The top level holds the FSM, iteration counter, match matrix, and live and staged pointers.

## Test plan
- N=M=ITER=4… use N=M=4, ITER=3, after reset, all-ones request → o_valid in cycle 4; o_grant out0→in0, out1→in1, out2→in2, in3 unmatched; committed g=[1,0,0,0], a=[1,0,0,0].
- Repeat the all-ones request immediately after the previous result → full match out0→in1, out1→in0, out2→in2, out3→in3 in cycle 4; g=[2,1,0,0], a=[2,1,0,0].
- Single request in2→out3 → early termination; o_valid in cycle 2, o_grant[3]=4'b0010 (in2 only), g[3]=3, a[2]=0 (wrap).
- All-zero request → o_valid in cycle 2, o_grant='0; then an all-ones request produces the same result as scenario 1 started from identical pointers.
- Hold i_valid=1 with a changing matrix while busy → only the matrix from the handshake cycle is used; o_ready is 0 in cycles 1..k_last+1.
- Assert reset_n=0 during cycle 2 of scenario 2 → o_valid never pulses, o_grant='0, o_ready=1 after release; re-running all-ones reproduces scenario 1 exactly.
